// File: rtl/ram_slot_arbiter_pkg.sv
// ram_arb_pkg: shared types/constants for the RAM slot arbiter.
// Provides the arbiter state enum, the non-RAM read value and in_ram().
package ram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VID_WAIT,
    VID_HOLD,
    CPU_WAIT,
    CPU_HOLD
  } arb_state_t;

  localparam logic [7:0] NONRAM_DATA = 8'hFF;

  function automatic logic in_ram(
    input logic [15:0] addr,
    input logic [15:0] top
  );
    return addr < top;
  endfunction

endpackage

// File: rtl/ram_slot_arbiter_if.sv
// ram_slot_arbiter_if: phase/video/CPU/RAM bus of the slot arbiter.
// slave = arbiter side, master = clock generator, CPU and RAM side.
interface ram_slot_arbiter_if;
  logic        phase0;
  logic [15:0] video_addr;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_dout;
  logic [7:0]  ram_q;
  logic [15:0] ram_addr;
  logic [7:0]  ram_d;
  logic        ram_we;
  logic [7:0]  video_data;
  logic        video_strobe;
  logic [7:0]  cpu_din;
  logic        cpu_strobe;
  logic        arb_overrun;

  modport slave (
    input  phase0, video_addr, cpu_addr,
    input  cpu_we, cpu_dout, ram_q,
    output ram_addr, ram_d, ram_we,
    output video_data, video_strobe,
    output cpu_din, cpu_strobe,
    output arb_overrun
  );

  modport master (
    output phase0, video_addr, cpu_addr,
    output cpu_we, cpu_dout, ram_q,
    input  ram_addr, ram_d, ram_we,
    input  video_data, video_strobe,
    input  cpu_din, cpu_strobe,
    input  arb_overrun
  );
endinterface

// File: rtl/ram_slot_arbiter_phase_edge.sv
// phase_edge_detect: registers phase0 and flags its rise/fall.
// Ports: clk_i, rst_ni (sync, active-low), phase_i, rise_o, fall_o.
module phase_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic phase_i,
  output logic rise_o,
  output logic fall_o
);

  logic phase_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) phase_q <= 1'b0;
    else         phase_q <= phase_i;
  end

  assign rise_o = ~phase_q & phase_i;
  assign fall_o = phase_q & ~phase_i;

endmodule

// File: rtl/ram_slot_arbiter.sv
// ram_slot_arbiter: video slot (phase0 low) / CPU slot (phase0 high)
// sharing of one sync RAM. Ports: clock_14Mhz, RESET_N, bus_if (slave).
// Macro FLOATING_BUS_EN: non-RAM CPU reads return video_data, else 8'hFF.
module ram_slot_arbiter
  import ram_arb_pkg::*;
#(
  parameter int          RAM_LATENCY = 1,
  parameter logic [15:0] RAM_TOP     = 16'hC000
) (
  input logic               clock_14Mhz,
  input logic               RESET_N,
  ram_slot_arbiter_if.slave bus_if
);

  localparam logic [2:0] LAT = 3'(RAM_LATENCY);

  logic rise, fall;

  phase_edge_detect u_edge (
    .clk_i   (clock_14Mhz),
    .rst_ni  (RESET_N),
    .phase_i (bus_if.phase0),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  arb_state_t  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        nonram_q, nonram_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_d_q, ram_d_d;
  logic        ram_we_q, ram_we_d;
  logic [7:0]  vdata_q, vdata_d;
  logic        vstb_q, vstb_d;
  logic [7:0]  cdin_q, cdin_d;
  logic        cstb_q, cstb_d;
  logic        ovr_q, ovr_d;

  logic        pending;
  logic        rise_ok;
  logic        cpu_in_ram;
  logic [7:0]  nonram_val;

`ifdef FLOATING_BUS_EN
  assign nonram_val = vdata_q;
`else
  assign nonram_val = NONRAM_DATA;
`endif

  assign pending    = (state_q == VID_WAIT) ||
                      (state_q == CPU_WAIT);
  // Rises are ignored until the first fall so video gets the first slot.
  assign rise_ok    = rise && (state_q != IDLE);
  assign cpu_in_ram = in_ram(bus_if.cpu_addr, RAM_TOP);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    nonram_d   = nonram_q;
    ram_addr_d = ram_addr_q;
    ram_d_d    = ram_d_q;
    ram_we_d   = 1'b0;
    vdata_d    = vdata_q;
    vstb_d     = 1'b0;
    cdin_d     = cdin_q;
    cstb_d     = 1'b0;
    ovr_d      = ovr_q;
    unique case (1'b1)
      fall: begin
        if (pending) ovr_d = 1'b1;
        ram_addr_d = bus_if.video_addr;
        cnt_d      = 3'd0;
        nonram_d   = 1'b0;
        state_d    = VID_WAIT;
      end
      rise_ok: begin
        if (pending) ovr_d = 1'b1;
        ram_addr_d = bus_if.cpu_addr;
        ram_d_d    = bus_if.cpu_dout;
        cnt_d      = 3'd0;
        nonram_d   = !cpu_in_ram;
        if (bus_if.cpu_we && cpu_in_ram) begin
          ram_we_d = 1'b1;
          state_d  = CPU_HOLD;
        end else begin
          state_d  = CPU_WAIT;
        end
      end
      default: begin
        unique case (state_q)
          VID_WAIT: begin
            if (cnt_q == LAT) begin
              vdata_d = bus_if.ram_q;
              vstb_d  = 1'b1;
              state_d = VID_HOLD;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
          CPU_WAIT: begin
            if (nonram_q) begin
              cdin_d  = nonram_val;
              cstb_d  = 1'b1;
              state_d = CPU_HOLD;
            end else if (cnt_q == LAT) begin
              cdin_d  = bus_if.ram_q;
              cstb_d  = 1'b1;
              state_d = CPU_HOLD;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
          default: ;
        endcase
      end
    endcase
  end

  always_ff @(posedge clock_14Mhz) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      nonram_q   <= 1'b0;
      ram_addr_q <= 16'h0000;
      ram_d_q    <= 8'h00;
      ram_we_q   <= 1'b0;
      vdata_q    <= 8'h00;
      vstb_q     <= 1'b0;
      cdin_q     <= 8'hFF;
      cstb_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nonram_q   <= nonram_d;
      ram_addr_q <= ram_addr_d;
      ram_d_q    <= ram_d_d;
      ram_we_q   <= ram_we_d;
      vdata_q    <= vdata_d;
      vstb_q     <= vstb_d;
      cdin_q     <= cdin_d;
      cstb_q     <= cstb_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus_if.ram_addr     = ram_addr_q;
  assign bus_if.ram_d        = ram_d_q;
  assign bus_if.ram_we       = ram_we_q;
  assign bus_if.video_data   = vdata_q;
  assign bus_if.video_strobe = vstb_q;
  assign bus_if.cpu_din      = cdin_q;
  assign bus_if.cpu_strobe   = cstb_q;
  assign bus_if.arb_overrun  = ovr_q;

endmodule

// File: tb/tb_ram_slot_arbiter.sv
// tb_ram_slot_arbiter: directed table + hand sequences for the arbiter.
// DUT A uses RAM_LATENCY=1, DUT B uses RAM_LATENCY=4.
module tb_ram_slot_arbiter;

`ifdef FLOATING_BUS_EN
  localparam logic [7:0] NR = 8'hA0;
`else
  localparam logic [7:0] NR = 8'hFF;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstA_n, rstB_n;

  ram_slot_arbiter_if ifA ();
  ram_slot_arbiter_if ifB ();

  ram_slot_arbiter #(.RAM_LATENCY(1), .RAM_TOP(16'hC000)) dutA (
    .clock_14Mhz (clk),
    .RESET_N     (rstA_n),
    .bus_if      (ifA.slave)
  );

  ram_slot_arbiter #(.RAM_LATENCY(4), .RAM_TOP(16'hC000)) dutB (
    .clock_14Mhz (clk),
    .RESET_N     (rstB_n),
    .bus_if      (ifB.slave)
  );

  logic [7:0] memA [0:65535];
  logic [7:0] memB [0:65535];
  logic [7:0] pB   [0:3];

  always @(posedge clk) begin
    if (ifA.ram_we) memA[ifA.ram_addr] <= ifA.ram_d;
    ifA.ram_q <= memA[ifA.ram_addr];
  end

  always @(posedge clk) begin
    if (ifB.ram_we) memB[ifB.ram_addr] <= ifB.ram_d;
    pB[0] <= memB[ifB.ram_addr];
    pB[1] <= pB[0];
    pB[2] <= pB[1];
    pB[3] <= pB[2];
  end
  assign ifB.ram_q = pB[3];

  typedef struct {
    logic        ph;
    logic [15:0] va;
    logic [15:0] ca;
    logic        we;
    logic [7:0]  dout;
    logic        evs;
    logic        ecs;
    logic        ewe;
    logic [7:0]  evd;
    logic [7:0]  ecd;
    logic [15:0] eaddr;
  } vec_t;

  vec_t tbl [$];
  logic [7:0] evd_t = 8'h00;
  logic [7:0] ecd_t = 8'hFF;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input int idx,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // One 7-clock half-cycle; soff = offset of the strobe, -1 for none.
  task automatic add_half(input logic ph, input logic [15:0] va,
                          input logic [15:0] ca, input logic we,
                          input logic [7:0] dout, input int soff,
                          input logic [7:0] nd, input logic wk0,
                          input logic [15:0] eaddr);
    vec_t v;
    for (int k = 0; k < 7; k++) begin
      v.ph = ph; v.va = va; v.ca = ca; v.we = we; v.dout = dout;
      v.evs = (ph == 1'b0) && (k == soff);
      v.ecs = (ph == 1'b1) && (k == soff);
      v.ewe = wk0 && (k == 0);
      if (k == soff) begin
        if (ph) ecd_t = nd;
        else    evd_t = nd;
      end
      v.evd = evd_t;
      v.ecd = ecd_t;
      v.eaddr = eaddr;
      tbl.push_back(v);
    end
  endtask

  task automatic stepA();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] snapA();
    return {20'h0, ifA.ram_addr, ifA.ram_d, ifA.ram_we,
            ifA.video_data, ifA.video_strobe,
            ifA.cpu_din, ifA.cpu_strobe, ifA.arb_overrun};
  endfunction

  function automatic logic [63:0] rst_exp();
    return {20'h0, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0,
            8'hFF, 1'b0, 1'b0};
  endfunction

  initial begin
    memA[16'h0400] = 8'hA0;
    memA[16'h0401] = 8'hA1;
    memA[16'h0800] = 8'h00;
    memA[16'hC030] = 8'h77;
    memB[16'h0400] = 8'hC4;
    rstA_n = 1'b0; rstB_n = 1'b0;
    ifA.phase0 = 1'b0; ifA.video_addr = 16'h0400;
    ifA.cpu_addr = 16'h0; ifA.cpu_we = 1'b0; ifA.cpu_dout = 8'h0;
    ifB.phase0 = 1'b0; ifB.video_addr = 16'h0400;
    ifB.cpu_addr = 16'h0400; ifB.cpu_we = 1'b0; ifB.cpu_dout = 8'h0;

    add_half(1, 16'h0400, 16'h0000, 0, 8'h00, -1, 8'h00, 0, 16'h0000);
    add_half(0, 16'h0400, 16'h0000, 0, 8'h00,  2, 8'hA0, 0, 16'h0400);
    add_half(1, 16'h0400, 16'h0800, 1, 8'h5A, -1, 8'h00, 1, 16'h0800);
    add_half(0, 16'h0400, 16'h0800, 0, 8'h00,  2, 8'hA0, 0, 16'h0400);
    add_half(1, 16'h0400, 16'h0800, 0, 8'h00,  2, 8'h5A, 0, 16'h0800);
    add_half(0, 16'h0400, 16'h0800, 0, 8'h00,  2, 8'hA0, 0, 16'h0400);
    add_half(1, 16'h0400, 16'hC030, 1, 8'h11,  1, NR,    0, 16'hC030);
    add_half(0, 16'h0400, 16'hC030, 0, 8'h00,  2, 8'hA0, 0, 16'h0400);
    add_half(1, 16'h0400, 16'hC030, 0, 8'h00,  1, NR,    0, 16'hC030);
    add_half(0, 16'h0401, 16'hC030, 0, 8'h00,  2, 8'hA1, 0, 16'h0401);

    repeat (3) stepA();
    chk("resetA", 0, snapA(), rst_exp());

    rstA_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      ifA.phase0     = tbl[i].ph;
      ifA.video_addr = tbl[i].va;
      ifA.cpu_addr   = tbl[i].ca;
      ifA.cpu_we     = tbl[i].we;
      ifA.cpu_dout   = tbl[i].dout;
      stepA();
      chk("video_strobe", i, 64'(ifA.video_strobe), 64'(tbl[i].evs));
      chk("video_data",   i, 64'(ifA.video_data),   64'(tbl[i].evd));
      chk("cpu_strobe",   i, 64'(ifA.cpu_strobe),   64'(tbl[i].ecs));
      chk("cpu_din",      i, 64'(ifA.cpu_din),      64'(tbl[i].ecd));
      chk("ram_we",       i, 64'(ifA.ram_we),       64'(tbl[i].ewe));
      chk("ram_addr",     i, 64'(ifA.ram_addr),     64'(tbl[i].eaddr));
      chk("overrun",      i, 64'(ifA.arb_overrun),  64'h0);
      if (tbl[i].ewe)
        chk("ram_d", i, 64'(ifA.ram_d), 64'(tbl[i].dout));
    end
    chk("mem_0800", 0, 64'(memA[16'h0800]), 64'h5A);
    chk("mem_C030", 0, 64'(memA[16'hC030]), 64'h77);

    // Reset asserted while the write strobe is high.
    ifA.phase0 = 1'b1; ifA.cpu_addr = 16'h0900;
    ifA.cpu_we = 1'b1; ifA.cpu_dout = 8'h3C;
    stepA();
    chk("midwr_we", 0, 64'(ifA.ram_we), 64'h1);
    rstA_n = 1'b0;
    stepA();
    chk("midwr_rst", 0, snapA(), rst_exp());
    rstA_n = 1'b1;
    ifA.cpu_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      stepA();
      chk("idle_hold", k, snapA(), rst_exp());
    end
    ifA.phase0 = 1'b0; ifA.video_addr = 16'h0400;
    for (int k = 0; k < 4; k++) begin
      stepA();
      chk("refall_addr", k, 64'(ifA.ram_addr), 64'h0400);
      chk("refall_vs", k, 64'(ifA.video_strobe), 64'(k == 2));
    end
    chk("refall_vd", 0, 64'(ifA.video_data), 64'hA0);

    // Latency 4: fits a 7-clock half, overruns a 4-clock half.
    rstB_n = 1'b1;
    ifB.phase0 = 1'b1;
    repeat (2) stepA();
    ifB.phase0 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      stepA();
      chk("b_vs", k, 64'(ifB.video_strobe), 64'(k == 5));
    end
    chk("b_vd", 0, 64'(ifB.video_data), 64'hC4);
    chk("b_ovr0", 0, 64'(ifB.arb_overrun), 64'h0);
    for (int h = 0; h < 4; h++) begin
      ifB.phase0 = ~h[0];
      for (int k = 0; k < 4; k++) begin
        stepA();
        chk("b_strobes", h * 4 + k,
            64'({ifB.video_strobe, ifB.cpu_strobe}), 64'h0);
        chk("b_ovr", h * 4 + k, 64'(ifB.arb_overrun),
            64'(h > 0));
      end
    end
    rstB_n = 1'b0;
    stepA();
    chk("b_ovr_rst", 0, 64'(ifB.arb_overrun), 64'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ram_slot_arbiter.md
Name: ram_slot_arbiter

Overview:
- Time-multiplexes the single 64K x 8 main RAM between the video scanner and the 6502 core, in the same interleave as the original machine.
- phase0 low half-cycle = video slot; phase0 high half-cycle = CPU slot.
- Sits between clock_generator (phase0, video_addr) and the block-RAM main memory.
- Delivers the video byte to the shift/display path and the CPU read byte to the CPU data mux.

Parameters:
- RAM_LATENCY, 1, synchronous RAM read latency in clock_14Mhz cycles; legal range 1..4.
- RAM_TOP, 16'hC000, first address that is not RAM; CPU accesses at or above it never touch RAM.

Ports:
- clock_14Mhz input 1 — sole clock, 14.31818 MHz.
- RESET_N input 1 — synchronous, active-low reset.
- phase0 input 1 — CPU phase from clock_generator.
- video_addr input 16 — scanner address from clock_generator.
- cpu_addr input 16 — CPU address, stable while phase0 high.
- cpu_we input 1 — CPU write enable, sampled at slot start.
- cpu_dout input 8 — CPU write data.
- ram_q input 8 — RAM read data.
- ram_addr output 16 — RAM address.
- ram_d output 8 — RAM write data.
- ram_we output 1 — RAM write strobe.
- video_data output 8 — last fetched video byte.
- video_strobe output 1 — one-clock pulse when video_data updates.
- cpu_din output 8 — CPU read data.
- cpu_strobe output 1 — one-clock pulse when cpu_din updates.
- arb_overrun output 1 — sticky: a slot was cut short by the next phase0 edge.

Behaviour:
- Interface (already decided): one clock, clock_14Mhz; reset RESET_N is synchronous and active-low.
- Reset values: all outputs 0 except cpu_din = 8'hFF. State = IDLE. phase0_d = 0.
- Edge detect:
  - phase0_d is a register of phase0.
  - fall = phase0_d & ~phase0.
  - rise = ~phase0_d & phase0.
- States: IDLE, VID_WAIT, VID_HOLD, CPU_WAIT, CPU_HOLD.
- IDLE: ignore everything until the first fall. This guarantees a full video slot first after reset.
- On fall (edge E0), from any state:
  - ram_addr <= video_addr; ram_we <= 0; wait counter <= 0; state -> VID_WAIT.
- VID_WAIT:
  - Counter increments each clock.
  - At edge E(RAM_LATENCY+1): video_data <= ram_q, video_strobe = 1 for that following cycle, state -> VID_HOLD.
- On rise (edge E0), from any state:
  - ram_addr <= cpu_addr; ram_d <= cpu_dout; counter <= 0.
  - Qualified write (cpu_we = 1 and cpu_addr < RAM_TOP): ram_we = 1 for exactly one cycle (E0 to E1), state -> CPU_HOLD, no cpu_strobe.
  - Read with cpu_addr < RAM_TOP: state -> CPU_WAIT. At E(RAM_LATENCY+1): cpu_din <= ram_q, cpu_strobe pulse, state -> CPU_HOLD.
  - Access at or above RAM_TOP: ram_we = 0; at E1 cpu_din <= non-RAM value (see Optional Feature), cpu_strobe pulse, state -> CPU_HOLD.
- HOLD states keep ram_addr and ram_d stable until the next edge.
- Overrun: a phase0 edge arriving while in VID_WAIT or CPU_WAIT abandons the pending latch (no strobe) and sets arb_overrun = 1. arb_overrun is cleared only by reset.
- Stretched cycle (8-clock half): the extra clock stays in the HOLD state; no effect on latency.
- Reset mid-write: ram_we = 0 on the same edge; no partial write is reported.
- cpu_we and cpu_dout changes after E0 are ignored.
- Both strobes are never high together (separate half-cycles).

Optional Feature:
- FLOATING_BUS_EN defined: a CPU read at or above RAM_TOP returns the current video_data (emulates the floating bus).
- FLOATING_BUS_EN undefined: such reads return 8'hFF.
- RAM behaviour is unchanged in both cases.

Decomposition:
- Package ram_arb_pkg:
  - enum arb_state_t {IDLE, VID_WAIT, VID_HOLD, CPU_WAIT, CPU_HOLD};
  - localparam NONRAM_DATA = 8'hFF;
  - function in_ram(addr, top).
- Sub-module phase_edge_detect: registers phase0 and outputs rise/fall. It is reusable by other phase-synchronous peripherals.

Test Plan:
- Reset, then a 14-clock phase0 pattern (7 low/7 high), RAM_LATENCY=1, video_addr=16'h0400 holding 8'hA0 -> first strobe: video_strobe exactly 2 clocks after the fall-detect edge, video_data=8'hA0; no strobe before the first fall.
- CPU write in the high half: cpu_addr=16'h0800, cpu_we=1, cpu_dout=8'h5A -> ram_we high exactly 1 cycle with ram_addr=16'h0800, ram_d=8'h5A.
- CPU read after the write: cpu_addr=16'h0800 -> cpu_din=8'h5A with cpu_strobe 2 clocks after rise detect.
- CPU write to 16'hC030 -> ram_we never asserted, RAM unchanged. Read of 16'hC030 -> cpu_din=8'hFF, or the last video_data (8'hA0) with FLOATING_BUS_EN.
- RAM_LATENCY=4 with a 4-clock half-cycle -> no strobe, arb_overrun=1 and stays 1 until RESET_N=0.
- Assert RESET_N=0 during the write cycle -> ram_we=0 on the same edge; all outputs at reset values; state=IDLE until the next fall.
